// File: rtl/sccb_lut_loader_if.sv
// Byte-stream, response and LUT-write signals of the OV7670 LUT loader.
// The master side is the loader; the slave side is the UART/config fabric.
interface sccb_lut_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        w_enable;
   logic [7:0]  w_addr;
   logic [15:0] w_data;

   modport master (
      input  rx_data, rx_valid, tx_ready,
      output rx_ready, tx_data, tx_valid,
      output w_enable, w_addr, w_data
   );

   modport slave (
      output rx_data, rx_valid, tx_ready,
      input  rx_ready, tx_data, tx_valid,
      input  w_enable, w_addr, w_data
   );
endinterface

// File: rtl/sccb_lut_loader.sv
// Parses SYNC/ADDR/DHI/DLO/CHK frames from the UART, writes the SCCB
// register LUT on a good checksum and answers each frame with ACK or NAK.
module sccb_lut_loader #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter logic [7:0] ACK_BYTE       = 8'h06,
   parameter logic [7:0] NAK_BYTE       = 8'h15,
   parameter int         TIMEOUT_CYCLES = 250000
) (
   input  logic        iCLK,
   input  logic        iRST,
   sccb_lut_loader_if.master bus,
   output logic [7:0]  frame_cnt,
   output logic [7:0]  err_cnt,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DHI, S_DLO, S_CHK, S_WRITE, S_RESP
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  dhi_q, dhi_d;
   logic [7:0]  dlo_q, dlo_d;
   logic [7:0]  waddr_q, waddr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [7:0]  tx_q, tx_d;
   logic [7:0]  fcnt_q, fcnt_d;
   logic [7:0]  ecnt_q, ecnt_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic       rdy;
   logic       accept;
   logic       in_frame;
   logic       tmo_hit;
   logic [7:0] ecnt_inc;

   assign rdy      = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                     (state_q == S_DHI)  || (state_q == S_DLO)  ||
                     (state_q == S_CHK);
   assign in_frame = rdy && (state_q != S_IDLE);
   assign accept   = rdy && bus.rx_valid;
   // A byte landing on the expiry cycle wins over the timeout.
   assign tmo_hit  = in_frame && !accept && (tmo_q == TMAX);
   assign ecnt_inc = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      dhi_d        = dhi_q;
      dlo_d        = dlo_q;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      tx_d         = tx_q;
      fcnt_d       = fcnt_q;
      ecnt_d       = ecnt_q;
      tmo_d        = '0;
      bus.w_enable = 1'b0;
      bus.tx_valid = 1'b0;

      if (in_frame && !accept) tmo_d = tmo_q + TW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (accept && bus.rx_data == SYNC_BYTE) state_d = S_ADDR;
         end
         S_ADDR: begin
            if (accept) begin
               addr_d  = bus.rx_data;
               state_d = S_DHI;
            end
         end
         S_DHI: begin
            if (accept) begin
               dhi_d   = bus.rx_data;
               state_d = S_DLO;
            end
         end
         S_DLO: begin
            if (accept) begin
               dlo_d   = bus.rx_data;
               state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (accept) begin
               if (bus.rx_data == (addr_q ^ dhi_q ^ dlo_q)) begin
                  waddr_d = addr_q;
                  wdata_d = {dhi_q, dlo_q};
                  state_d = S_WRITE;
               end else begin
                  tx_d    = NAK_BYTE;
                  ecnt_d  = ecnt_inc;
                  state_d = S_RESP;
               end
            end
         end
         S_WRITE: begin
            bus.w_enable = 1'b1;
            fcnt_d       = fcnt_q + 8'd1;
            tx_d         = ACK_BYTE;
            state_d      = S_RESP;
         end
         S_RESP: begin
            bus.tx_valid = 1'b1;
            if (bus.tx_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (tmo_hit) begin
         tx_d    = NAK_BYTE;
         ecnt_d  = ecnt_inc;
         state_d = S_RESP;
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         dhi_q   <= '0;
         dlo_q   <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         tx_q    <= '0;
         fcnt_q  <= '0;
         ecnt_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         dhi_q   <= dhi_d;
         dlo_q   <= dlo_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         tx_q    <= tx_d;
         fcnt_q  <= fcnt_d;
         ecnt_q  <= ecnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.rx_ready = rdy;
   assign bus.tx_data  = tx_q;
   assign bus.w_addr   = waddr_q;
   assign bus.w_data   = wdata_q;
   assign frame_cnt    = fcnt_q;
   assign err_cnt      = ecnt_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sccb_lut_loader.sv
// Bench for sccb_lut_loader: vector table, corner sequences and
// random frames checked against a frame-level reference model.
module tb_sccb_lut_loader;
   localparam int TMO = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] frame_cnt;
   logic [7:0] err_cnt;
   logic       busy;

   sccb_lut_loader_if bus();

   sccb_lut_loader #(.TIMEOUT_CYCLES(TMO)) dut (
      .iCLK(clk),
      .iRST(rst),
      .bus(bus),
      .frame_cnt(frame_cnt),
      .err_cnt(err_cnt),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int          m_frames = 0;
   int          m_errs   = 0;
   logic [23:0] m_last   = '0;

   logic [7:0]  resp_q[$];
   logic [23:0] wr_q[$];

   always @(negedge clk) begin
      if (bus.tx_valid && bus.tx_ready) resp_q.push_back(bus.tx_data);
      if (bus.w_enable) wr_q.push_back({bus.w_addr, bus.w_data});
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] h;
      logic [7:0] l;
      logic [7:0] c;
      logic [7:0] r;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      while (!bus.rx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         total++;
         bad++;
         $display("FAIL rx_accept: byte %0h never taken", b);
      end
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_resp(output logic [7:0] r);
      int n = 0;
      while (resp_q.size() == 0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (resp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL resp_wait: no response got none want one");
         r = 8'h00;
      end else begin
         r = resp_q.pop_front();
      end
   endtask

   task automatic send_bytes5(input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] c);
      logic good;
      good = (c == (a ^ h ^ l));
      wr_q.delete();
      resp_q.delete();
      send_byte(8'hA5);
      send_byte(a);
      send_byte(h);
      send_byte(l);
      send_byte(c);
      chk("lat_wen", {31'd0, bus.w_enable}, {31'd0, good});
      chk("lat_txv", {31'd0, bus.tx_valid}, {31'd0, !good});
   endtask

   task automatic finish_frame(input logic [7:0] a, input logic [7:0] h,
                               input logic [7:0] l, input logic [7:0] c,
                               input logic [7:0] exp_r);
      logic [7:0] r;
      logic good;
      good = (c == (a ^ h ^ l));
      wait_resp(r);
      chk("resp", {24'd0, r}, {24'd0, exp_r});
      if (good) begin
         m_frames++;
         m_last = {a, h, l};
      end else begin
         m_errs++;
      end
      chk("wr_count", wr_q.size(), good ? 1 : 0);
      if (good && wr_q.size() == 1) chk("wr_val", {8'd0, wr_q[0]}, {8'd0, a, h, l});
      chk("wr_hold", {8'd0, bus.w_addr, bus.w_data}, {8'd0, m_last});
      chk("frame_cnt", {24'd0, frame_cnt}, m_frames % 256);
      chk("err_cnt", {24'd0, err_cnt}, (m_errs > 255) ? 255 : m_errs);
      chk("busy_idle", {31'd0, busy}, 0);
      wr_q.delete();
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                             input logic [7:0] l, input logic [7:0] c,
                             input logic [7:0] exp_r);
      send_bytes5(a, h, l, c);
      finish_frame(a, h, l, c, exp_r);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 1);
      chk({tag, "_tx_valid"}, {31'd0, bus.tx_valid}, 0);
      chk({tag, "_tx_data"}, {24'd0, bus.tx_data}, 0);
      chk({tag, "_w_enable"}, {31'd0, bus.w_enable}, 0);
      chk({tag, "_w_addr"}, {24'd0, bus.w_addr}, 0);
      chk({tag, "_w_data"}, {16'd0, bus.w_data}, 0);
      chk({tag, "_frame_cnt"}, {24'd0, frame_cnt}, 0);
      chk({tag, "_err_cnt"}, {24'd0, err_cnt}, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
   endtask

   initial begin
      vec_t vecs[7];
      logic [7:0] a, h, l, c, r;
      int n;
      int hold_err;

      vecs[0] = '{8'h10, 8'h12, 8'h34, 8'h36, 8'h06};
      vecs[1] = '{8'h10, 8'h12, 8'h34, 8'h00, 8'h15};
      vecs[2] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h06};
      vecs[3] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h06};
      vecs[4] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h06};
      vecs[5] = '{8'h20, 8'hAB, 8'hCD, 8'h46, 8'h06};
      vecs[6] = '{8'h20, 8'hAB, 8'hCD, 8'h47, 8'h15};

      rst          = 1'b1;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst0");
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         if (i == 2) begin
            resp_q.delete();
            wr_q.delete();
            send_byte(8'h00);
            send_byte(8'hFF);
            send_byte(8'h3A);
            repeat (4) @(posedge clk);
            #1;
            chk("junk_resp", resp_q.size(), 0);
            chk("junk_wr", wr_q.size(), 0);
            chk("junk_busy", {31'd0, busy}, 0);
         end
         send_frame(vecs[i].a, vecs[i].h, vecs[i].l, vecs[i].c, vecs[i].r);
      end

      // Inter-byte timeout after a partial frame.
      resp_q.delete();
      wr_q.delete();
      send_byte(8'hA5);
      send_byte(8'h20);
      n = 0;
      while (!bus.tx_valid && n < 3 * TMO) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_window", {31'd0, (n >= TMO - 1) && (n <= TMO + 2)}, 1);
      wait_resp(r);
      chk("tmo_resp", {24'd0, r}, 8'h15);
      m_errs++;
      chk("tmo_err_cnt", {24'd0, err_cnt}, m_errs);
      chk("tmo_wr", wr_q.size(), 0);
      @(posedge clk);
      #1;
      chk("tmo_idle", {31'd0, busy}, 0);
      send_frame(8'h07, 8'h08, 8'h09, 8'h07 ^ 8'h08 ^ 8'h09, 8'h06);

      // Slow but in-time bytes must not time out.
      wr_q.delete();
      resp_q.delete();
      a = 8'h11; h = 8'h22; l = 8'h33; c = a ^ h ^ l;
      send_byte(8'hA5);
      repeat (TMO - 4) @(posedge clk);
      #1;
      send_byte(a);
      repeat (TMO - 4) @(posedge clk);
      #1;
      send_byte(h);
      repeat (TMO - 4) @(posedge clk);
      #1;
      send_byte(l);
      repeat (TMO - 4) @(posedge clk);
      #1;
      send_byte(c);
      finish_frame(a, h, l, c, 8'h06);

      // Back-pressure on the response.
      bus.tx_ready = 1'b0;
      a = 8'h33; h = 8'h44; l = 8'h55; c = a ^ h ^ l;
      send_bytes5(a, h, l, c);
      @(posedge clk);
      #1;
      bus.rx_data  = 8'hA5;
      bus.rx_valid = 1'b1;
      hold_err = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!(bus.tx_valid && bus.tx_data == 8'h06 &&
               !bus.rx_ready && busy)) hold_err++;
      end
      chk("hold_stable", hold_err, 0);
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b1;
      finish_frame(a, h, l, c, 8'h06);

      // Reset in the middle of a frame.
      resp_q.delete();
      wr_q.delete();
      send_byte(8'hA5);
      send_byte(8'h10);
      send_byte(8'h12);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset("rst1");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset("rst2");
      chk("rst_no_resp", resp_q.size(), 0);
      chk("rst_no_wr", wr_q.size(), 0);
      m_frames = 0;
      m_errs   = 0;
      m_last   = '0;

      for (int k = 0; k < 256; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            a = 8'($urandom_range(0, 255));
            if (a == 8'hA5) a = 8'h5A;
            send_byte(a);
         end
         a = 8'($urandom_range(0, 255));
         h = 8'($urandom_range(0, 255));
         l = 8'($urandom_range(0, 255));
         c = a ^ h ^ l;
         send_frame(a, h, l, c, 8'h06);
      end
      chk("frame_wrap", {24'd0, frame_cnt}, 0);

      for (int k = 0; k < 300; k++) begin
         a = 8'($urandom_range(0, 255));
         h = 8'($urandom_range(0, 255));
         l = 8'($urandom_range(0, 255));
         c = a ^ h ^ l ^ 8'($urandom_range(1, 255));
         send_frame(a, h, l, c, 8'h15);
      end
      chk("err_sat", {24'd0, err_cnt}, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
